tcm_port_arbiter: RTL and testbench

- Shares one single-port, 64-bit-wide TCM SRAM between the core's instruction-fetch port and its data port.
- Sits between riscv_core (mem_i_*/mem_d_* buses) and a raw synchronous SRAM macro.
- Performs the work that tcm_mem does internally with dual ports: per-cycle grant, read-response sequencing, tag return, and out-of-range error generation.

---
 rtl/tcm_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_tcm_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_port_arbiter.sv
// Arbitrates one single-port 64-bit TCM SRAM between the instruction-fetch
// and data ports of the core. Data normally wins. Fetch is forced through
// after STARVE_LIMIT consecutive denied cycles. Responses come back with a
// fixed one-cycle latency.
// Ports:
//   clk_i, rst_i            clock, async active-low reset
//   mem_i_*                 fetch request / response
//   mem_d_*                 data request / response (with tag return)
//   ram_*                   raw synchronous SRAM macro (read data next cycle)
module tcm_port_arbiter #(
  parameter logic [31:0] TCM_BASE     = 32'h8000_0000,
  parameter int unsigned TCM_AW       = 14,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_i_rd_i,
  input  logic              mem_i_flush_i,
  input  logic              mem_i_invalidate_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [63:0]       mem_i_inst_o,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [10:0]       mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_writeback_i,
  input  logic              mem_d_flush_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [10:0]       mem_d_resp_tag_o,
  output logic              ram_en_o,
  output logic [7:0]        ram_wr_o,
  output logic [TCM_AW-1:0] ram_addr_o,
  output logic [63:0]       ram_wdata_o,
  input  logic [63:0]       ram_rdata_i
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned TAG_W     = 11;
  localparam logic [32:0] WIN_BYTES = 33'(33'd8 << TCM_AW);

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_FETCH = 2'd1,
    SRC_DATA  = 2'd2
  } resp_src_e;

  logic             d_rw;
  logic             d_req;
  logic             grant_d;
  logic             grant_i;
  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      acc_addr;
  logic [32:0]      acc_off;
  logic             acc_in_range;

  resp_src_e        resp_src;
  logic             resp_err;
  logic             resp_rd;
  logic             resp_hi;
  logic [TAG_W-1:0] resp_tag;

  // Flush/invalidate on fetch and the cacheable hint have no effect here.
  logic unused_inputs;
  assign unused_inputs = mem_i_flush_i ^ mem_i_invalidate_i ^ mem_d_cacheable_i;

  // Request decode and single-winner grant.
  assign d_rw    = mem_d_rd_i | (|mem_d_wr_i);
  assign d_req   = d_rw | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign grant_d = rst_i & d_req & (starve_cnt < CNT_W'(STARVE_LIMIT));
  assign grant_i = rst_i & mem_i_rd_i & ~grant_d;

  assign mem_d_accept_o = grant_d;
  assign mem_i_accept_o = grant_i;

  // 33-bit offset so addresses below the base wrap to a huge value and
  // fail the window check.
  assign acc_addr     = grant_d ? mem_d_addr_i : mem_i_pc_i;
  assign acc_off      = {1'b0, acc_addr} - {1'b0, TCM_BASE};
  assign acc_in_range = acc_off < WIN_BYTES;

  // Consecutive denied-fetch counter, saturating at the limit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= '0;
    end else if (!mem_i_rd_i || grant_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // SRAM drive for in-range fetches and data reads/writes only.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_wr_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (acc_in_range && (grant_i || (grant_d && d_rw))) begin
      ram_en_o   = 1'b1;
      ram_addr_o = acc_off[TCM_AW+2:3];
      if (grant_d && (|mem_d_wr_i)) begin
        ram_wr_o    = mem_d_addr_i[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
        ram_wdata_o = {2{mem_d_data_wr_i}};
      end
    end
  end

  // One-deep response pipeline; overlaps the next grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_src <= SRC_NONE;
      resp_err <= 1'b0;
      resp_rd  <= 1'b0;
      resp_hi  <= 1'b0;
      resp_tag <= '0;
    end else begin
      resp_src <= grant_d ? SRC_DATA : (grant_i ? SRC_FETCH : SRC_NONE);
      resp_err <= grant_d ? (d_rw & ~acc_in_range) : (grant_i & ~acc_in_range);
      resp_rd  <= grant_d & mem_d_rd_i & ~(|mem_d_wr_i) & acc_in_range;
      if (grant_d) begin
        resp_hi  <= mem_d_addr_i[2];
        resp_tag <= mem_d_req_tag_i;
      end
    end
  end

  // Response formatting; read data is zeroed for anything but a good read.
  always_comb begin
    mem_i_valid_o    = (resp_src == SRC_FETCH);
    mem_i_error_o    = (resp_src == SRC_FETCH) & resp_err;
    mem_i_inst_o     = ((resp_src == SRC_FETCH) && !resp_err) ? ram_rdata_i : '0;
    mem_d_ack_o      = (resp_src == SRC_DATA);
    mem_d_error_o    = (resp_src == SRC_DATA) & resp_err;
    mem_d_resp_tag_o = resp_tag;
    mem_d_data_rd_o  = '0;
    if (resp_rd) begin
      mem_d_data_rd_o = resp_hi ? ram_rdata_i[63:32] : ram_rdata_i[31:0];
    end
  end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: directed plan steps followed by random traffic,
// checked every cycle against a transaction-level model with its own memory.
module tb_tcm_port_arbiter;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          AW    = 14;
  localparam int          LIMIT = 4;
  localparam logic [63:0] WIN   = 64'd8 << AW;
  localparam int          NDW   = 1 << AW;

  logic          clk_i;
  logic          rst_i;
  logic          mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
  logic [31:0]   mem_i_pc_i;
  logic          mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [63:0]   mem_i_inst_o;
  logic [31:0]   mem_d_addr_i, mem_d_data_wr_i;
  logic          mem_d_rd_i;
  logic [3:0]    mem_d_wr_i;
  logic          mem_d_cacheable_i;
  logic [10:0]   mem_d_req_tag_i;
  logic          mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
  logic          mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0]   mem_d_data_rd_o;
  logic [10:0]   mem_d_resp_tag_o;
  logic          ram_en_o;
  logic [7:0]    ram_wr_o;
  logic [AW-1:0] ram_addr_o;
  logic [63:0]   ram_wdata_o;
  logic [63:0]   ram_rdata_i;

  tcm_port_arbiter #(.TCM_BASE(BASE), .TCM_AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
    .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
    .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_accept_o(mem_d_accept_o),
    .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_resp_tag_o(mem_d_resp_tag_o),
    .ram_en_o(ram_en_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Environment SRAM macro: read data appears one cycle after enable.
  logic [63:0] sram [NDW];
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      ram_rdata_i <= sram[ram_addr_o];
      for (int b = 0; b < 8; b++)
        if (ram_wr_o[b]) sram[ram_addr_o][b*8 +: 8] = ram_wdata_o[b*8 +: 8];
    end
  end

  // Reference model state.
  logic [63:0] mmem [NDW];
  int          m_starve;
  int          p_kind;     // 0 none, 1 fetch, 2 data
  bit          p_err;
  logic [10:0] p_tag;
  logic [63:0] p_inst;
  logic [31:0] p_data;

  int          n_cmp;
  int          n_bad;

  // Observations kept for the plan-level constant checks.
  bit          s_gd;
  logic [7:0]  s_ram_wr;
  logic [63:0] s_i_inst;
  logic [31:0] s_d_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    logic [63:0] ua;
    logic [63:0] ub;
    ua = 64'(a);
    ub = 64'(BASE);
    return (ua >= ub) && (ua < ub + WIN);
  endfunction

  function automatic int dw_idx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic idle();
    mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0;
    mem_d_rd_i = 0; mem_d_wr_i = 4'h0; mem_d_invalidate_i = 0;
    mem_d_writeback_i = 0; mem_d_flush_i = 0; mem_d_cacheable_i = 0;
  endtask

  task automatic preload(input int idx, input logic [63:0] v);
    sram[idx] = v;
    mmem[idx] = v;
  endtask

  // One clock: check at negedge against the model, commit the model at posedge.
  task automatic cycle();
    bit rw, dreq, gd, gi, inr_d, e_en;
    logic [31:0] a;
    logic [7:0]  e_wr;
    int          nk;
    bit          n_err;
    logic [63:0] n_inst;
    logic [31:0] n_data;
    @(negedge clk_i);
    if (!rst_i) begin
      p_kind   = 0;
      m_starve = 0;
    end
    rw    = mem_d_rd_i || (|mem_d_wr_i);
    dreq  = rw || mem_d_invalidate_i || mem_d_writeback_i || mem_d_flush_i;
    gd    = rst_i && dreq && (m_starve < LIMIT);
    gi    = rst_i && mem_i_rd_i && !gd;
    inr_d = in_win(mem_d_addr_i);
    chk("d_accept", 64'(mem_d_accept_o), 64'(gd));
    chk("i_accept", 64'(mem_i_accept_o), 64'(gi));
    e_en = (gi && in_win(mem_i_pc_i)) || (gd && rw && inr_d);
    chk("ram_en", 64'(ram_en_o), 64'(e_en));
    if (e_en) begin
      a    = gd ? mem_d_addr_i : mem_i_pc_i;
      e_wr = gd ? (8'(mem_d_wr_i) << (mem_d_addr_i[2] ? 4 : 0)) : 8'h00;
      chk("ram_addr", 64'(ram_addr_o), 64'((a - BASE) >> 3));
      chk("ram_wr", 64'(ram_wr_o), 64'(e_wr));
      if (gd && (|mem_d_wr_i))
        chk("ram_wdata", ram_wdata_o, {mem_d_data_wr_i, mem_d_data_wr_i});
    end
    chk("i_valid", 64'(mem_i_valid_o), 64'(p_kind == 1));
    chk("i_error", 64'(mem_i_error_o), 64'(p_kind == 1 && p_err));
    if (p_kind == 1) chk("i_inst", mem_i_inst_o, p_inst);
    chk("d_ack", 64'(mem_d_ack_o), 64'(p_kind == 2));
    chk("d_error", 64'(mem_d_error_o), 64'(p_kind == 2 && p_err));
    if (p_kind == 2) begin
      chk("d_tag", 64'(mem_d_resp_tag_o), 64'(p_tag));
      chk("d_data", 64'(mem_d_data_rd_o), 64'(p_data));
    end
    if (!rst_i) begin
      chk("rst_inst", mem_i_inst_o, 64'h0);
      chk("rst_data", 64'(mem_d_data_rd_o), 64'h0);
      chk("rst_tag", 64'(mem_d_resp_tag_o), 64'h0);
    end
    s_gd = mem_d_accept_o; s_ram_wr = ram_wr_o;
    s_i_inst = mem_i_inst_o; s_d_data = mem_d_data_rd_o;
    // Next response as seen from the transaction's point of view.
    nk = gd ? 2 : (gi ? 1 : 0);
    n_err = 0; n_inst = '0; n_data = '0;
    if (gi) begin
      n_err  = !in_win(mem_i_pc_i);
      n_inst = n_err ? 64'h0 : mmem[dw_idx(mem_i_pc_i)];
    end
    if (gd) begin
      n_err = rw && !inr_d;
      if (mem_d_rd_i && !(|mem_d_wr_i) && inr_d)
        n_data = mem_d_addr_i[2] ? mmem[dw_idx(mem_d_addr_i)][63:32]
                                 : mmem[dw_idx(mem_d_addr_i)][31:0];
    end
    @(posedge clk_i);
    if (rst_i) begin
      if (!mem_i_rd_i || gi) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      p_kind = nk; p_err = n_err; p_inst = n_inst; p_data = n_data;
      if (gd) begin
        p_tag = mem_d_req_tag_i;
        if ((|mem_d_wr_i) && inr_d)
          for (int b = 0; b < 4; b++)
            if (mem_d_wr_i[b])
              mmem[dw_idx(mem_d_addr_i)][(mem_d_addr_i[2] ? 32 : 0) + 8*b +: 8] =
                mem_d_data_wr_i[8*b +: 8];
      end
    end else begin
      p_kind = 0; m_starve = 0;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input bit fetch);
    int r;
    r = $urandom_range(0, 19);
    case (r)
      0: return BASE - 32'd8;
      1: return BASE + 32'(WIN);
      2: return BASE + 32'(WIN) - 32'd8;
      3: return $urandom;
      default: return BASE + 32'($urandom_range(0, 63) << 3) +
                      (fetch ? 32'd0 : 32'($urandom_range(0, 1) * 4));
    endcase
  endfunction

  initial begin
    logic [11:0] pat;
    int          k;
    n_cmp = 0; n_bad = 0; m_starve = 0; p_kind = 0;
    p_err = 0; p_tag = '0; p_inst = '0; p_data = '0;
    for (int i = 0; i < NDW; i++) preload(i, 64'h0);
    preload(2, 64'h1111_2222_3333_4444);
    idle();
    mem_i_pc_i = '0; mem_d_addr_i = '0; mem_d_data_wr_i = '0; mem_d_req_tag_i = '0;
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    cycle(); cycle();
    rst_i = 1'b1;
    cycle();

    // Single fetch of dword 2.
    mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0010;
    cycle();
    idle();
    cycle();
    chk("plan_inst", s_i_inst, 64'h1111_2222_3333_4444);

    // Write low half-word into the upper lane, then read it back.
    mem_d_addr_i = 32'h8000_0004; mem_d_data_wr_i = 32'hDEAD_BEEF;
    mem_d_wr_i = 4'b0011; mem_d_req_tag_i = 11'h155;
    cycle();
    chk("plan_wr", 64'(s_ram_wr), 64'h30);
    idle();
    mem_d_rd_i = 1; mem_d_req_tag_i = 11'h2AA;
    cycle();
    idle();
    cycle();
    chk("plan_rd", 64'(s_d_data), 64'h0000_BEEF);

    // Continuous contention: data wins four times, then fetch.
    mem_i_rd_i = 1; mem_i_pc_i = BASE + 32'h20;
    mem_d_rd_i = 1; mem_d_addr_i = BASE + 32'h40; mem_d_req_tag_i = 11'h011;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      pat = {pat[10:0], s_gd};
    end
    chk("plan_pattern", 64'(pat), 64'(12'b1111_0111_1011));

    // Out-of-range data read and fetch.
    idle();
    mem_d_rd_i = 1; mem_d_addr_i = 32'h8002_0000; mem_d_req_tag_i = 11'h033;
    mem_i_rd_i = 1; mem_i_pc_i = 32'h7FFF_FFF8;
    cycle();
    mem_d_rd_i = 0;
    cycle();
    idle();
    cycle();

    // Flush alongside a fetch.
    mem_d_flush_i = 1; mem_d_req_tag_i = 11'h07F;
    mem_i_rd_i = 1; mem_i_pc_i = BASE + 32'h8;
    cycle();
    mem_d_flush_i = 0;
    cycle();
    idle();
    cycle();

    // Reset right after a data grant drops the in-flight response.
    mem_d_rd_i = 1; mem_d_addr_i = BASE + 32'h10; mem_d_req_tag_i = 11'h003;
    cycle();
    idle();
    rst_i = 1'b0;
    cycle(); cycle();
    rst_i = 1'b1;
    mem_i_rd_i = 1; mem_i_pc_i = BASE + 32'h10;
    cycle();
    idle();
    cycle();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      idle();
      rst_i = ($urandom_range(0, 99) != 0);
      mem_i_rd_i = ($urandom_range(0, 2) != 0);
      mem_i_pc_i = rand_addr(1'b1) | 32'($urandom_range(0, 7));
      mem_i_flush_i = ($urandom_range(0, 15) == 0);
      mem_d_cacheable_i = 1'($urandom);
      mem_d_addr_i = rand_addr(1'b0);
      mem_d_data_wr_i = $urandom;
      mem_d_req_tag_i = 11'($urandom);
      k = $urandom_range(0, 9);
      case (k)
        4, 5: mem_d_rd_i = 1;
        6, 7: mem_d_wr_i = 4'($urandom);
        8: begin
          mem_d_flush_i = 1'($urandom);
          mem_d_invalidate_i = 1'($urandom);
          mem_d_writeback_i = 1;
        end
        9: begin
          mem_d_rd_i = 1;
          mem_d_flush_i = 1;
        end
        default: ;
      endcase
      cycle();
    end
    idle();
    rst_i = 1'b1;
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
